// File: rtl/h14rx_period_tracker.sv
// HDMI 1.4 TMDS receive period tracker: classifies each deskewed character
// (control, preamble, guard, video, island) and flags guard/island framing errors.
module h14rx_period_tracker #(
    parameter int PreambleMin = 8,
    parameter int MaxPackets  = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sym0,
    input  logic [9:0] sym1,
    input  logic [9:0] sym2,
    output logic [2:0] period,
    output logic [1:0] sync,
    output logic [3:0] ctl,
    output logic [4:0] pkt_idx,
    output logic [4:0] char_idx,
    output logic [9:0] sym_out0,
    output logic [9:0] sym_out1,
    output logic [9:0] sym_out2,
    output logic       err_guard,
    output logic       err_island
);
    localparam logic [9:0] G1 = 10'b0100110011;
    localparam logic [9:0] G0 = 10'b1011001100;

    typedef enum logic [2:0] {
        CTRL   = 3'd0,
        PRE_V  = 3'd1,
        PRE_D  = 3'd2,
        VGUARD = 3'd3,
        VIDEO  = 3'd4,
        DLEAD  = 3'd5,
        ISLAND = 3'd6,
        DTRAIL = 3'd7
    } state_t;

    function automatic logic is_tok(input logic [9:0] s);
        return (s == 10'b1101010100) || (s == 10'b0010101011) ||
               (s == 10'b0101010100) || (s == 10'b1010101011);
    endfunction

    function automatic logic [1:0] tok_dec(input logic [9:0] s);
        case (s)
            10'b0010101011: return 2'b01;
            10'b0101010100: return 2'b10;
            10'b1010101011: return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       gcnt_q, gcnt_d;
    logic [4:0] pkt_q, pkt_d, chr_q, chr_d;
    logic [1:0] sync_q, sync_d;
    logic [3:0] ctl_q, ctl_d;
    logic       eg_q, eg_d, ei_q, ei_d;
    logic [9:0] so0_q, so1_q, so2_q;

    logic       all_tok, pre_v, pre_d, vguard, dguard, armed, boundary;
    logic [3:0] run_inc;
    logic [4:0] pkt_inc, chr_inc;

    assign all_tok  = is_tok(sym0) && is_tok(sym1) && is_tok(sym2);
    assign pre_v    = all_tok && tok_dec(sym1) == 2'b01 && tok_dec(sym2) == 2'b00;
    assign pre_d    = all_tok && tok_dec(sym1) == 2'b01 && tok_dec(sym2) == 2'b01;
    assign vguard   = sym0 == G0 && sym1 == G1 && sym2 == G0;
    assign dguard   = sym1 == G1 && sym2 == G1;
    assign armed    = run_q >= 4'(PreambleMin);
    assign run_inc  = (run_q == 4'hF) ? run_q : run_q + 4'd1;
    assign boundary = chr_q == 5'd31;
    assign chr_inc  = chr_q + 5'd1;
    assign pkt_inc  = pkt_q + 5'd1;

    // Control-family rules, shared by the control states and the character after a trailing guard pair.
    state_t     cf_state;
    logic [3:0] cf_run;
    logic       cf_err;

    always_comb begin
        cf_state = CTRL;
        cf_run   = '0;
        cf_err   = 1'b0;
        if (sym1 == G1) begin
            if (vguard && state_q == PRE_V && armed)      cf_state = VGUARD;
            else if (dguard && state_q == PRE_D && armed) cf_state = DLEAD;
            else                                          cf_err   = 1'b1;
        end else if (pre_v) begin
            cf_state = PRE_V;
            cf_run   = (state_q == PRE_V) ? run_inc : 4'd1;
        end else if (pre_d) begin
            cf_state = PRE_D;
            cf_run   = (state_q == PRE_D) ? run_inc : 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CTRL;
            run_q   <= '0;
            gcnt_q  <= 1'b0;
            pkt_q   <= '0;
            chr_q   <= '0;
            sync_q  <= '0;
            ctl_q   <= '0;
            eg_q    <= 1'b0;
            ei_q    <= 1'b0;
            so0_q   <= '0;
            so1_q   <= '0;
            so2_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            gcnt_q  <= gcnt_d;
            pkt_q   <= pkt_d;
            chr_q   <= chr_d;
            sync_q  <= sync_d;
            ctl_q   <= ctl_d;
            eg_q    <= eg_d;
            ei_q    <= ei_d;
            so0_q   <= sym0;
            so1_q   <= sym1;
            so2_q   <= sym2;
        end
    end

    always_comb begin
        logic use_cf;
        use_cf  = 1'b0;
        state_d = state_q;
        run_d   = run_q;
        gcnt_d  = gcnt_q;
        pkt_d   = pkt_q;
        chr_d   = chr_q;
        sync_d  = sync_q;
        ctl_d   = ctl_q;
        eg_d    = 1'b0;
        ei_d    = 1'b0;
        case (state_q)
            CTRL, PRE_V, PRE_D: use_cf = 1'b1;
            VGUARD: begin
                if (gcnt_q) begin
                    state_d = VIDEO;
                    gcnt_d  = 1'b0;
                end else if (vguard) begin
                    gcnt_d = 1'b1;
                end else begin
                    eg_d    = 1'b1;
                    state_d = CTRL;
                end
            end
            DLEAD: begin
                if (gcnt_q) begin
                    state_d = ISLAND;
                    gcnt_d  = 1'b0;
                    pkt_d   = '0;
                    chr_d   = '0;
                end else if (dguard) begin
                    gcnt_d = 1'b1;
                end else begin
                    eg_d    = 1'b1;
                    state_d = CTRL;
                end
            end
            VIDEO: begin
                if (is_tok(sym0)) begin
                    state_d = CTRL;
                    run_d   = '0;
                    sync_d  = tok_dec(sym0);
                    if (is_tok(sym1)) ctl_d[1:0] = tok_dec(sym1);
                    if (is_tok(sym2)) ctl_d[3:2] = tok_dec(sym2);
                end
            end
            ISLAND: begin
                // A trailing guard is only legal where the next packet would start.
                if (boundary && dguard) begin
                    state_d = DTRAIL;
                    gcnt_d  = 1'b0;
                end else if (boundary && pkt_inc >= 5'(MaxPackets)) begin
                    ei_d    = 1'b1;
                    state_d = CTRL;
                end else if (is_tok(sym0) || (!boundary && (sym1 == G1 || sym2 == G1))) begin
                    ei_d    = 1'b1;
                    state_d = CTRL;
                end else begin
                    chr_d = chr_inc;
                    pkt_d = boundary ? pkt_inc : pkt_q;
                end
            end
            DTRAIL: begin
                if (gcnt_q) begin
                    use_cf = 1'b1;
                end else if (dguard) begin
                    gcnt_d = 1'b1;
                end else begin
                    ei_d    = 1'b1;
                    state_d = CTRL;
                end
            end
            default: state_d = CTRL;
        endcase

        if (use_cf) begin
            state_d = cf_state;
            run_d   = cf_run;
            eg_d    = cf_err;
            gcnt_d  = 1'b0;
            if (all_tok) begin
                sync_d = tok_dec(sym0);
                ctl_d  = {tok_dec(sym2), tok_dec(sym1)};
            end
        end

        if (state_d == CTRL) run_d = '0;
        if (state_d != ISLAND && state_d != DTRAIL) begin
            pkt_d = '0;
            chr_d = '0;
        end
    end

    always_comb begin
        period     = state_q;
        sync       = sync_q;
        ctl        = ctl_q;
        pkt_idx    = pkt_q;
        char_idx   = chr_q;
        sym_out0   = so0_q;
        sym_out1   = so1_q;
        sym_out2   = so2_q;
        err_guard  = eg_q;
        err_island = ei_q;
    end
endmodule

// File: tb/tb_h14rx_period_tracker.sv
// Bench for h14rx_period_tracker: hand table, directed framing sequences and
// randomized segments checked against a position-counting reference model.
module tb_h14rx_period_tracker;
    localparam int PMIN = 8;
    localparam int MAXP = 18;
    localparam logic [9:0] G1 = 10'b0100110011;
    localparam logic [9:0] G0 = 10'b1011001100;
    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;

    logic       clk, rst_n;
    logic [9:0] s0, s1, s2;
    logic [2:0] period;
    logic [1:0] sync;
    logic [3:0] ctl;
    logic [4:0] pkt_idx, char_idx;
    logic [9:0] so0, so1, so2;
    logic       err_guard, err_island;

    h14rx_period_tracker #(.PreambleMin(PMIN), .MaxPackets(MAXP)) dut (
        .clk(clk), .rst_n(rst_n), .sym0(s0), .sym1(s1), .sym2(s2),
        .period(period), .sync(sync), .ctl(ctl), .pkt_idx(pkt_idx), .char_idx(char_idx),
        .sym_out0(so0), .sym_out1(so1), .sym_out2(so2),
        .err_guard(err_guard), .err_island(err_island)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    string phase = "init";
    int    pcount [8];
    int    errs_seen;

    // Reference model: island progress is a single running character count.
    int         m_mode, m_run, m_gs, m_pos;
    logic [1:0] m_sync;
    logic [3:0] m_ctl;
    logic       m_eg, m_ei;
    logic [9:0] m_so0, m_so1, m_so2;

    function automatic logic istok(input logic [9:0] v);
        return v == T0 || v == T1 || v == T2 || v == T3;
    endfunction

    function automatic logic [1:0] dec(input logic [9:0] v);
        if (v == T1) return 2'd1;
        if (v == T2) return 2'd2;
        if (v == T3) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [9:0] tok(input int i);
        case (i & 3)
            0: return T0;
            1: return T1;
            2: return T2;
            default: return T3;
        endcase
    endfunction

    function automatic logic [9:0] good_sym();
        logic [9:0] v;
        v = 10'($urandom);
        if (istok(v) || v == G0 || v == G1) v[0] = ~v[0];
        return v;
    endfunction

    task automatic m_ctrl(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        int p;
        if (b == G1) begin
            if (a == G0 && c == G0 && m_mode == 1 && m_run >= PMIN) begin m_mode = 3; m_gs = 1; end
            else if (c == G1 && m_mode == 2 && m_run >= PMIN)      begin m_mode = 5; m_gs = 1; end
            else begin m_eg = 1'b1; m_mode = 0; end
            m_run = 0;
        end else if (istok(a) && istok(b) && istok(c)) begin
            m_sync = dec(a);
            m_ctl  = {dec(c), dec(b)};
            if (dec(b) == 1 && dec(c) == 0)      p = 1;
            else if (dec(b) == 1 && dec(c) == 1) p = 2;
            else                                 p = 0;
            if (p == 0)           m_run = 0;
            else if (p == m_mode) m_run = (m_run < 15) ? m_run + 1 : 15;
            else                  m_run = 1;
            m_mode = p;
        end else begin
            m_mode = 0;
            m_run  = 0;
        end
    endtask

    task automatic m_step(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic r);
        int np;
        logic bnd;
        m_eg = 1'b0;
        m_ei = 1'b0;
        if (!r) begin
            m_mode = 0; m_run = 0; m_gs = 0; m_pos = 0;
            m_sync = '0; m_ctl = '0;
            m_so0 = '0; m_so1 = '0; m_so2 = '0;
            return;
        end
        m_so0 = a; m_so1 = b; m_so2 = c;
        case (m_mode)
            0, 1, 2: m_ctrl(a, b, c);
            3: if (m_gs == 2) m_mode = 4;
               else if (a == G0 && b == G1 && c == G0) m_gs = 2;
               else begin m_eg = 1'b1; m_mode = 0; end
            5: if (m_gs == 2) begin m_mode = 6; m_pos = 0; end
               else if (b == G1 && c == G1) m_gs = 2;
               else begin m_eg = 1'b1; m_mode = 0; end
            4: if (istok(a)) begin
                   m_sync = dec(a);
                   if (istok(b)) m_ctl[1:0] = dec(b);
                   if (istok(c)) m_ctl[3:2] = dec(c);
                   m_mode = 0; m_run = 0;
               end
            6: begin
                np  = m_pos + 1;
                bnd = (np % 32) == 0;
                if (bnd && b == G1 && c == G1) begin m_mode = 7; m_gs = 1; end
                else if (bnd && np / 32 >= MAXP) begin m_ei = 1'b1; m_mode = 0; end
                else if (istok(a) || (!bnd && (b == G1 || c == G1))) begin m_ei = 1'b1; m_mode = 0; end
                else m_pos = np;
            end
            default: if (m_gs == 2) m_ctrl(a, b, c);
                     else if (b == G1 && c == G1) m_gs = 2;
                     else begin m_ei = 1'b1; m_mode = 0; end
        endcase
        if (m_mode == 0) m_run = 0;
    endtask

    task automatic cmp_model();
        int ep, ec;
        ep = (m_mode == 6 || m_mode == 7) ? m_pos / 32 : 0;
        ec = (m_mode == 6 || m_mode == 7) ? m_pos % 32 : 0;
        total++;
        if (period !== 3'(m_mode) || sync !== m_sync || ctl !== m_ctl ||
            pkt_idx !== 5'(ep) || char_idx !== 5'(ec) ||
            err_guard !== m_eg || err_island !== m_ei ||
            so0 !== m_so0 || so1 !== m_so1 || so2 !== m_so2) begin
            bad++;
            $display("FAIL model[%s] got p=%0d sy=%b ctl=%b pk=%0d ch=%0d eg=%b ei=%b so=%h/%h/%h exp p=%0d sy=%b ctl=%b pk=%0d ch=%0d eg=%b ei=%b so=%h/%h/%h",
                     phase, period, sync, ctl, pkt_idx, char_idx, err_guard, err_island, so0, so1, so2,
                     m_mode, m_sync, m_ctl, ep, ec, m_eg, m_ei, m_so0, m_so1, m_so2);
        end
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic apply(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic r);
        s0 = a; s1 = b; s2 = c; rst_n = r;
        m_step(a, b, c, r);
        @(posedge clk);
        #1;
        cmp_model();
        pcount[period]++;
        if (err_guard || err_island) errs_seen++;
    endtask

    task automatic clr_stats();
        foreach (pcount[i]) pcount[i] = 0;
        errs_seen = 0;
    endtask

    task automatic vpre(input int n);
        for (int i = 0; i < n; i++) apply(T0, T1, T0, 1'b1);
    endtask
    task automatic dpre(input int n);
        for (int i = 0; i < n; i++) apply(T0, T1, T1, 1'b1);
    endtask
    task automatic vgd(input int n);
        for (int i = 0; i < n; i++) apply(G0, G1, G0, 1'b1);
    endtask
    task automatic dgd(input int n);
        for (int i = 0; i < n; i++) apply(good_sym(), G1, G1, 1'b1);
    endtask
    task automatic pix(input int n);
        for (int i = 0; i < n; i++) apply(good_sym(), good_sym(), good_sym(), 1'b1);
    endtask

    typedef struct {
        logic       rst_n;
        logic [9:0] a, b, c;
        logic [2:0] p;
        logic [1:0] sy;
        logic [3:0] cl;
        logic       eg, ei;
    } vec_t;
    vec_t tbl [11];

    initial begin
        rst_n = 1'b0; s0 = '0; s1 = '0; s2 = '0;
        clr_stats();
        m_step('0, '0, '0, 1'b0);

        tbl[0] = '{1'b0, T0, T1, T0, 3'd0, 2'b00, 4'b0000, 1'b0, 1'b0};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{1'b1, T0, T1, T0, 3'd1, 2'b00, 4'b0001, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, G0, G1, G0, 3'd0, 2'b00, 4'b0001, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, G0, G1, G0, 3'd0, 2'b00, 4'b0001, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, T3, T1, T1, 3'd2, 2'b11, 4'b0101, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, T0, T0, T0, 3'd0, 2'b00, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, G0, G1, G1, 3'd0, 2'b00, 4'b0000, 1'b1, 1'b0};

        phase = "table";
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].rst_n);
            expect_eq($sformatf("table%0d_flags", i),
                      int'({period, sync, ctl, err_guard, err_island, pkt_idx, char_idx}),
                      int'({tbl[i].p, tbl[i].sy, tbl[i].cl, tbl[i].eg, tbl[i].ei, 10'd0}));
            expect_eq($sformatf("table%0d_symout", i), int'({so0, so1, so2}),
                      tbl[i].rst_n ? int'({tbl[i].a, tbl[i].b, tbl[i].c}) : 0);
        end

        // Video frame line
        phase = "video";
        apply(T0, T0, T0, 1'b0);
        clr_stats();
        vpre(12);
        expect_eq("video_ctl", int'(ctl), 1);
        vgd(2);
        pix(100);
        apply(T0, T1, T0, 1'b1);
        expect_eq("video_n_pre", pcount[1], 12);
        expect_eq("video_n_guard", pcount[3], 2);
        expect_eq("video_n_pix", pcount[4], 100);
        expect_eq("video_end_period", int'(period), 0);
        expect_eq("video_end_ctl", int'(ctl), 1);
        expect_eq("video_errs", errs_seen, 0);

        // Two-packet island with trailing guards
        phase = "island2";
        clr_stats();
        dpre(8);
        dgd(2);
        for (int i = 0; i < 64; i++) begin
            apply(good_sym(), good_sym(), good_sym(), 1'b1);
            if (i == 0 || i == 33 || i == 63)
                expect_eq($sformatf("island_idx%0d", i), int'({pkt_idx, char_idx}), (i / 32) * 32 + (i % 32));
        end
        dgd(2);
        expect_eq("dtrail_hold", int'({period, pkt_idx, char_idx}), (7 << 10) | (1 << 5) | 31);
        apply(T0, T0, T0, 1'b1);
        expect_eq("island2_end", int'(period), 0);
        expect_eq("island2_n_dtrail", pcount[7], 2);
        expect_eq("island2_errs", errs_seen, 0);

        // Island overrun at MaxPackets
        phase = "overrun";
        dpre(8);
        dgd(2);
        pix(576);
        expect_eq("overrun_prev_err", int'(err_island), 0);
        pix(1);
        expect_eq("overrun_err", int'({err_island, err_guard}), 2);
        expect_eq("overrun_period", int'(period), 0);

        // Misplaced guard inside a packet, then normal recovery
        phase = "midguard";
        dpre(8);
        dgd(2);
        pix(10);
        dgd(1);
        expect_eq("midguard_err", int'({err_island, period}), 8);
        vpre(8);
        vgd(2);
        pix(1);
        expect_eq("recover_video", int'(period), 4);

        // Reset in the middle of active video
        phase = "midreset";
        pix(40);
        apply(good_sym(), good_sym(), good_sym(), 1'b0);
        expect_eq("midreset_outs", int'({period, sync, ctl, pkt_idx, char_idx, err_guard, err_island}), 0);
        expect_eq("midreset_symout", int'({so0, so1, so2}), 0);
        vgd(1);
        expect_eq("post_reset_guard", int'({err_guard, period}), 8);

        // Randomized segments
        phase = "random";
        for (int seg = 0; seg < 160; seg++) begin
            case ($urandom_range(0, 8))
                0: for (int i = $urandom_range(1, 12); i > 0; i--)
                       apply(tok($urandom), T1, T0, 1'b1);
                1: for (int i = $urandom_range(1, 12); i > 0; i--)
                       apply(tok($urandom), T1, T1, 1'b1);
                2: vgd($urandom_range(1, 3));
                3: dgd($urandom_range(1, 3));
                4: pix($urandom_range(1, 50));
                5: for (int i = $urandom_range(1, 4); i > 0; i--)
                       apply(tok($urandom), tok($urandom), tok($urandom), 1'b1);
                6: for (int i = $urandom_range(1, 5); i > 0; i--)
                       apply(10'($urandom), 10'($urandom), 10'($urandom), 1'b1);
                7: apply(good_sym(), good_sym(), good_sym(), 1'b0);
                default: begin
                    dpre($urandom_range(7, 10));
                    dgd(2);
                    pix(32 * $urandom_range(1, 3) + $urandom_range(0, 1));
                    dgd($urandom_range(1, 2));
                    apply(T0, T0, T0, 1'b1);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
